cpri_chip_pingpong: RTL and testbench
=====================================

Name: cpri_chip_pingpong

Overview:
- Sits directly downstream of the CPRI RX data FIFO stage.
- Captures 64-bit words addressed by a 7-bit chip sequence number into one of two chip-sized banks (ping-pong).
- Once a full chip of CHIP_DW words is committed, it streams the chip in address order to the PUSCH dimension-reduction datapath over a valid/ready handshake.
- It decouples bursty CPRI arrival from downstream stalls and flags malformed chips.

Parameters:
DATA_WIDTH, 64, word width of RX and output data
ADDR_WIDTH, 7, chip sequence/address width
CHIP_DW, 96, words per chip; legal addresses 0..CHIP_DW-1
CNT_WIDTH, 16, width of delivered-chip counter

Ports:
i_clk  in  1  single clock
i_reset  in  1  synchronous active-high reset
i_rx_data  in  DATA_WIDTH  RX word from FIFO stage
i_rx_addr  in  ADDR_WIDTH  word index within chip
i_rx_last  in  1  marks final word of chip
i_rvalid  in  1  RX word valid
o_rready  out  1  write bank available; drives upstream read enable
o_data  out  DATA_WIDTH  chip word out
o_seq  out  ADDR_WIDTH  index of o_data within chip
o_sop  out  1  high with o_seq==0
o_eop  out  1  high with o_seq==CHIP_DW-1
o_valid  out  1  output word valid
i_tready  in  1  downstream accepts word
o_err_len  out  1  one-cycle pulse: chip closed with word count != CHIP_DW
o_overflow  out  1  sticky: word arrived with no free bank
o_chip_cnt  out  CNT_WIDTH  chips fully delivered, wraps

Behaviour:
- Reset, synchronous, takes priority over everything:
  - both banks empty, wr_bank=0, rd_bank=0, word counter 0.
  - All outputs 0 except o_rready=1 on the first cycle after reset.
  - Reset mid-chip discards all stored and partly delivered data.
- Storage: two banks of CHIP_DW x DATA_WIDTH registered-read RAM; bank state is full/empty.
- o_rready is 1 when bank wr_bank is empty. It is decoded from registers only, with no combinational path from any input.
- Write path:
  - i_rvalid & o_rready: write i_rx_data to bank[wr_bank][i_rx_addr] and increment the word counter.
  - Addresses >= CHIP_DW are not written but are still counted.
- Close:
  - i_rvalid & o_rready & i_rx_last: mark wr_bank full, toggle wr_bank, clear the word counter.
  - If the count including this word != CHIP_DW, pulse o_err_len the next cycle. The chip is still committed as is; unwritten entries hold stale data.
- Overflow: i_rvalid while o_rready=0 drops the word and sets o_overflow. o_overflow clears only on reset.
- Read FSM states:
  - IDLE: when bank rd_bank is full, go to READ.
  - READ: issue RAM addresses 0..CHIP_DW-1, advancing only when the output register is empty or being accepted. One word per cycle with i_tready held high.
  - DRAIN: after the final address is issued, hold until the word with o_seq=CHIP_DW-1 is handshaken. Then mark rd_bank empty, toggle rd_bank, increment o_chip_cnt, return to IDLE.
- Latency: o_valid first rises on the 2nd rising edge after the edge that captured the closing write.
- Back-to-back: if the other bank is already full at DRAIN exit, READ starts in the following cycle. Chip gap is at most 2 idle output cycles.
- Handshake:
  - A word transfers when o_valid & i_tready.
  - While o_valid=1 & i_tready=0, o_data, o_seq, o_sop and o_eop hold stable.
  - The pipeline must not lose or duplicate words under any i_tready pattern (skid/prefetch register required).
- Simultaneous close and free:
  - A bank freed by the read side in cycle N is writable (o_rready=1) in cycle N+1.
  - Close and free of different banks in the same cycle are both honoured.
- o_sop and o_eop derive from o_seq, not from i_rx_last.
- o_chip_cnt increments by 1 per delivered chip and wraps 0xFFFF->0.

Test Plan:
- Single chip: i_tready=1, words addr 0..95 with data=addr, last on 95 -> o_valid rises 2 edges after the last write; 96 consecutive words with o_data=o_seq=0..95; o_sop on 0, o_eop on 95; o_chip_cnt=1; o_err_len never pulses.
- Ping-pong full: i_tready=0, write 2 chips -> o_rready=0 after the 2nd close. Then i_tready=1 -> o_rready returns 1 one cycle after the handshake of chip 0 word 95; output order is chip 0 then chip 1.
- Random backpressure: i_tready 50% random over 10 chips -> 960 words in order, no drop or duplication, outputs held stable during every stall cycle, o_chip_cnt=10.
- Short chip: last asserted on addr 89 after 90 words -> o_err_len pulses once; chip of 96 words still delivered; o_chip_cnt=1.
- Overflow: third chip driven while both banks are full -> o_overflow=1 and stays 1; first two chips are delivered intact.
- Reset mid-read: assert i_reset while streaming word 40 -> next cycle o_valid=0, o_chip_cnt=0, o_overflow=0, o_rready=1; a fresh chip then delivers correctly from seq 0.

Source files
------------

// File: rtl/cpri_chip_pingpong.sv
// Ping-pong chip buffer between the CPRI RX FIFO stage and the PUSCH
// dimension-reduction datapath. Two chip-sized banks alternate between
// being filled by address-tagged RX words and being streamed out in
// address order over a valid/ready handshake.
module cpri_chip_pingpong #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int CHIP_DW    = 96,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [ADDR_WIDTH-1:0] i_rx_addr,
    input  logic                  i_rx_last,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_seq,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_valid,
    input  logic                  i_tready,
    output logic                  o_err_len,
    output logic                  o_overflow,
    output logic [CNT_WIDTH-1:0]  o_chip_cnt
);

    // Word counter is wide enough to tell over-long chips from exact ones;
    // it saturates rather than wrapping back onto CHIP_DW.
    localparam int WCNT_WIDTH = $clog2(CHIP_DW) + 2;
    localparam logic [WCNT_WIDTH-1:0] CHIP_WORDS  = WCNT_WIDTH'(CHIP_DW);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(CHIP_DW - 1);
    localparam logic [ADDR_WIDTH:0]   CHIP_DW_EXT = (ADDR_WIDTH + 1)'(CHIP_DW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } rd_state_t;

    // Bank bookkeeping
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WCNT_WIDTH-1:0] wcnt_inc;

    // Status
    logic                  err_len_q, err_len_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  chip_cnt_q, chip_cnt_d;

    // Read sequencer
    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    // Stage 1: RAM output register (valid flag + sequence tag)
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_seq_q, s1_seq_d;

    // Stage 2: output register seen by the downstream
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_seq_q, out_seq_d;

    // Handshake / control strobes
    logic                  wr_accept;
    logic                  wr_in_range;
    logic                  wr_close;
    logic                  rd_issue;
    logic                  chip_done;
    logic                  out_take;
    logic                  out_free;
    logic                  s1_move;
    logic                  s1_free;

    logic [DATA_WIDTH-1:0] bank_rdata [2];

    // Write bank is available whenever it holds no committed chip.
    assign o_rready    = ~bank_full_q[wr_bank_q];
    assign wr_accept   = i_rvalid & ~bank_full_q[wr_bank_q];
    assign wr_in_range = ({1'b0, i_rx_addr} < CHIP_DW_EXT);
    assign wr_close    = wr_accept & i_rx_last;
    assign wcnt_inc    = wcnt_q + WCNT_WIDTH'(1);

    // Output register may load when empty or when its word is being taken;
    // stage 1 may accept a new read when empty or when it moves forward.
    assign out_take = out_valid_q & i_tready;
    assign out_free = ~out_valid_q | i_tready;
    assign s1_move  = s1_valid_q & out_free;
    assign s1_free  = ~s1_valid_q | out_free;

    // Two chip banks, each a simple dual-port RAM with registered read
    // and a read enable so stage 1 holds its word while stalled.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [CHIP_DW];
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  we;
            logic                  re;

            assign we = ~i_reset & wr_accept & wr_in_range & (wr_bank_q == 1'(gi));
            assign re = ~i_reset & rd_issue & (rd_bank_q == 1'(gi));

            // Bank write port and registered read port
            always_ff @(posedge i_clk) begin
                if (we) begin
                    mem[i_rx_addr] <= i_rx_data;
                end
                if (re) begin
                    rdata_q <= mem[rd_addr_q];
                end
            end

            assign bank_rdata[gi] = rdata_q;
        end
    endgenerate

    // Write side: word counting, chip close, length error and overflow.
    always_comb begin
        wcnt_d     = wcnt_q;
        wr_bank_d  = wr_bank_q;
        err_len_d  = 1'b0;
        overflow_d = overflow_q;

        if (wr_close) begin
            wcnt_d    = '0;
            wr_bank_d = ~wr_bank_q;
            err_len_d = (wcnt_inc != CHIP_WORDS);
        end else if (wr_accept && (wcnt_q != '1)) begin
            wcnt_d = wcnt_inc;
        end

        if (i_rvalid && bank_full_q[wr_bank_q]) begin
            overflow_d = 1'b1;
        end
    end

    // Read sequencer next state: IDLE issues address 0 as soon as the read
    // bank is full so the first word reaches the output two edges later.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_issue  = 1'b0;
        chip_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_bank_q] && s1_free) begin
                    rd_issue  = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (s1_free) begin
                    rd_issue = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_take && (out_seq_q == LAST_ADDR)) begin
                    chip_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                rd_addr_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Bank ownership, chip counter and the two-stage output pipeline.
    always_comb begin
        bank_full_d = bank_full_q;
        rd_bank_d   = rd_bank_q;
        chip_cnt_d  = chip_cnt_q;
        s1_valid_d  = s1_valid_q;
        s1_seq_d    = s1_seq_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_seq_d   = out_seq_q;

        // Close and free always target different banks, so both apply.
        if (wr_close) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (chip_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            chip_cnt_d             = chip_cnt_q + CNT_WIDTH'(1);
        end

        if (rd_issue) begin
            s1_valid_d = 1'b1;
            s1_seq_d   = rd_addr_q;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        if (out_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = bank_rdata[rd_bank_q];
                out_seq_d  = s1_seq_q;
            end
        end
    end

    // State register; reset discards all stored and in-flight chips.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wcnt_q      <= '0;
            err_len_q   <= 1'b0;
            overflow_q  <= 1'b0;
            chip_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_seq_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_seq_q   <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wcnt_q      <= wcnt_d;
            err_len_q   <= err_len_d;
            overflow_q  <= overflow_d;
            chip_cnt_q  <= chip_cnt_d;
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_seq_q    <= s1_seq_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_seq_q   <= out_seq_d;
        end
    end

    assign o_valid    = out_valid_q;
    assign o_data     = out_data_q;
    assign o_seq      = out_seq_q;
    assign o_sop      = out_valid_q & (out_seq_q == '0);
    assign o_eop      = out_valid_q & (out_seq_q == LAST_ADDR);
    assign o_err_len  = err_len_q;
    assign o_overflow = overflow_q;
    assign o_chip_cnt = chip_cnt_q;

endmodule

// File: tb/tb_cpri_chip_pingpong.sv
// Directed bench for cpri_chip_pingpong: a bank model builds the expected
// chip stream on every close, and an output monitor pops and compares each
// delivered word, checks stall stability, chip counting and bank release.
module tb_cpri_chip_pingpong;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [63:0] i_rx_data;
    logic [6:0]  i_rx_addr;
    logic        i_rx_last;
    logic        i_rvalid;
    logic        o_rready;
    logic [63:0] o_data;
    logic [6:0]  o_seq;
    logic        o_sop;
    logic        o_eop;
    logic        o_valid;
    logic        i_tready;
    logic        o_err_len;
    logic        o_overflow;
    logic [15:0] o_chip_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard and bank model
    logic [63:0] q_data [$];
    logic [6:0]  q_seq  [$];
    logic [63:0] model_mem [2][96];
    bit          m_wr_bank = 1'b0;

    // 0: stall, 1: always ready, 2: random ready
    int          tmode = 0;
    int          err_seen = 0;
    logic [15:0] exp_cnt = '0;

    cpri_chip_pingpong dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_addr  (i_rx_addr),
        .i_rx_last  (i_rx_last),
        .i_rvalid   (i_rvalid),
        .o_rready   (o_rready),
        .o_data     (o_data),
        .o_seq      (o_seq),
        .o_sop      (o_sop),
        .o_eop      (o_eop),
        .o_valid    (o_valid),
        .i_tready   (i_tready),
        .o_err_len  (o_err_len),
        .o_overflow (o_overflow),
        .o_chip_cnt (o_chip_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready pattern
    initial begin
        i_tready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (tmode)
                1:       i_tready = 1'b1;
                2:       i_tready = 1'($urandom_range(0, 1));
                default: i_tready = 1'b0;
            endcase
        end
    end

    // Output monitor
    bit          hold_v = 1'b0;
    bit          eop_hs = 1'b0;
    logic [63:0] h_data;
    logic [6:0]  h_seq;
    logic        h_sop, h_eop;
    logic [63:0] e_data;
    logic [6:0]  e_seq;

    always @(negedge i_clk) begin
        if (i_reset === 1'b1) begin
            hold_v  = 1'b0;
            eop_hs  = 1'b0;
            exp_cnt = '0;
        end else begin
            if (o_err_len === 1'b1) err_seen++;
            check("chip_cnt", o_chip_cnt, exp_cnt);
            if (eop_hs) check("rready_after_free", o_rready, 1'b1);
            eop_hs = 1'b0;
            if (hold_v) begin
                check("stall_valid", o_valid, 1'b1);
                check("stall_data", o_data, h_data);
                check("stall_seq", o_seq, h_seq);
                check("stall_sop", o_sop, h_sop);
                check("stall_eop", o_eop, h_eop);
            end
            if (o_valid === 1'b1 && i_tready === 1'b1) begin
                if (q_data.size() == 0) begin
                    check("unexpected_word_seq", o_seq, 7'h7f);
                end else begin
                    e_data = q_data.pop_front();
                    e_seq  = q_seq.pop_front();
                    check("out_data", o_data, e_data);
                    check("out_seq", o_seq, e_seq);
                    check("out_sop", o_sop, (e_seq == 7'd0));
                    check("out_eop", o_eop, (e_seq == 7'd95));
                    $display("word seq=%0d data=%016h remaining=%0d", o_seq, o_data, q_data.size());
                    if (e_seq == 7'd95) begin
                        exp_cnt = exp_cnt + 16'd1;
                        eop_hs  = 1'b1;
                    end
                end
            end
            hold_v = (o_valid === 1'b1) && (i_tready !== 1'b1);
            h_data = o_data;
            h_seq  = o_seq;
            h_sop  = o_sop;
            h_eop  = o_eop;
        end
    end

    task automatic do_reset();
        i_reset  = 1'b1;
        i_rvalid = 1'b0;
        i_rx_last = 1'b0;
        q_data.delete();
        q_seq.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset   = 1'b0;
        m_wr_bank = 1'b0;
        err_seen  = 0;
    endtask

    task automatic send_word(input logic [63:0] data, input logic [6:0] addr,
                             input logic last, input bit wait_rdy);
        bit acc;
        int n;
        n = 0;
        if (wait_rdy) begin
            while (o_rready !== 1'b1 && n < 3000) begin
                @(posedge i_clk);
                #1;
                n++;
            end
            check("rready_wait", o_rready, 1'b1);
        end
        i_rx_data = data;
        i_rx_addr = addr;
        i_rx_last = last;
        i_rvalid  = 1'b1;
        acc = (o_rready === 1'b1);
        @(posedge i_clk);
        #1;
        i_rvalid  = 1'b0;
        i_rx_last = 1'b0;
        if (acc) begin
            if (addr < 7'd96) model_mem[m_wr_bank][addr] = data;
            if (last) begin
                for (int k = 0; k < 96; k++) begin
                    q_data.push_back(model_mem[m_wr_bank][k]);
                    q_seq.push_back(7'(k));
                end
                m_wr_bank = ~m_wr_bank;
            end
        end
    endtask

    task automatic send_chip(input logic [7:0] tag, input int nwords, input bit wait_rdy);
        logic [63:0] d;
        for (int a = 0; a < nwords; a++) begin
            d = {tag, 8'(a), 16'($urandom), $urandom};
            send_word(d, 7'(a), (a == nwords - 1), wait_rdy);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q_data.size() != 0 || o_valid === 1'b1) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_empty", q_data.size(), 0);
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        bit found;
        i_reset   = 1'b1;
        i_rx_data = '0;
        i_rx_addr = '0;
        i_rx_last = 1'b0;
        i_rvalid  = 1'b0;

        // Reset state and single chip with latency check
        tmode = 1;
        do_reset();
        @(negedge i_clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_rready", o_rready, 1'b1);
        check("rst_cnt", o_chip_cnt, 16'd0);
        check("rst_overflow", o_overflow, 1'b0);
        check("rst_err_len", o_err_len, 1'b0);
        check("rst_sop", o_sop, 1'b0);
        check("rst_eop", o_eop, 1'b0);
        check("rst_data", o_data, 64'd0);
        check("rst_seq", o_seq, 7'd0);
        for (int a = 0; a < 96; a++) begin
            send_word(64'(a), 7'(a), (a == 95), 1'b0);
        end
        @(negedge i_clk);
        check("lat_edge1_valid", o_valid, 1'b0);
        @(negedge i_clk);
        check("lat_edge1b_valid", o_valid, 1'b0);
        @(negedge i_clk);
        check("lat_edge2_valid", o_valid, 1'b1);
        check("lat_first_seq", o_seq, 7'd0);
        wait_drain(500);
        check("single_cnt", o_chip_cnt, 16'd1);
        check("single_no_err", err_seen, 0);

        // Ping-pong full under stall, then release
        do_reset();
        tmode = 0;
        send_chip(8'hA0, 96, 1'b0);
        send_chip(8'hA1, 96, 1'b0);
        @(negedge i_clk);
        check("pp_rready_low", o_rready, 1'b0);
        check("pp_valid_held", o_valid, 1'b1);
        check("pp_seq_held", o_seq, 7'd0);
        tmode = 1;
        wait_drain(1000);
        check("pp_cnt", o_chip_cnt, 16'd2);

        // Random backpressure over 10 chips
        do_reset();
        tmode = 2;
        for (int c = 0; c < 10; c++) begin
            send_chip(8'(8'hB0 + c), 96, 1'b1);
        end
        wait_drain(5000);
        check("rand_cnt", o_chip_cnt, 16'd10);
        check("rand_no_overflow", o_overflow, 1'b0);
        check("rand_no_err", err_seen, 0);

        // Short chip: 90 words, stale tail still delivered
        do_reset();
        tmode = 1;
        send_chip(8'hC0, 90, 1'b1);
        @(negedge i_clk);
        check("short_err_pulse", o_err_len, 1'b1);
        @(negedge i_clk);
        check("short_err_clear", o_err_len, 1'b0);
        wait_drain(500);
        check("short_cnt", o_chip_cnt, 16'd1);
        check("short_err_count", err_seen, 1);

        // Out-of-range address counted but not written: no length error
        for (int a = 0; a < 96; a++) begin
            send_word({8'hC1, 8'(a), 48'(a * 7)}, (a == 95) ? 7'd100 : 7'(a), (a == 95), 1'b1);
        end
        @(negedge i_clk);
        check("oor_no_err", o_err_len, 1'b0);
        wait_drain(500);
        check("oor_cnt", o_chip_cnt, 16'd2);
        check("oor_err_count", err_seen, 1);

        // Overflow with both banks full
        do_reset();
        tmode = 0;
        send_chip(8'hD0, 96, 1'b0);
        send_chip(8'hD1, 96, 1'b0);
        @(negedge i_clk);
        check("ovf_before", o_overflow, 1'b0);
        send_chip(8'hD2, 96, 1'b0);
        @(negedge i_clk);
        check("ovf_set", o_overflow, 1'b1);
        tmode = 1;
        wait_drain(1000);
        check("ovf_sticky", o_overflow, 1'b1);
        check("ovf_cnt", o_chip_cnt, 16'd2);

        // Reset while streaming word 40
        send_chip(8'hE0, 96, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1 && o_seq === 7'd40) found = 1'b1;
        end
        check("mid_seq40_found", found, 1'b1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        q_data.delete();
        q_seq.delete();
        @(posedge i_clk);
        #1;
        i_reset   = 1'b0;
        m_wr_bank = 1'b0;
        @(negedge i_clk);
        check("mid_valid", o_valid, 1'b0);
        check("mid_cnt", o_chip_cnt, 16'd0);
        check("mid_overflow", o_overflow, 1'b0);
        check("mid_rready", o_rready, 1'b1);
        send_chip(8'hE1, 96, 1'b1);
        wait_drain(500);
        check("mid_fresh_cnt", o_chip_cnt, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
